ps2_rx_fifo: RTL and testbench

- Parametrised PS/2 keyboard receiver, successor to the single-code receiver.
- Adds start, parity and stop checking, an inter-bit timeout, and E0/F0 prefix decoding into a 10-bit code.
- Decoded codes are buffered in a FIFO and read through a valid/ready handshake.
- Sits between the board PS/2 pins and the keyboard/command consumer logic.

---
 rtl/ps2_rx_fifo.sv | 188 ++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: framed/checked bytes, E0/F0 prefix decode, FIFO with valid/ready read.
// Latency: code_valid SYNC_STAGES+3 clk after the stop-bit fall; a push into a full FIFO without a pop is dropped (overflow).
module ps2_rx_fifo #(
    parameter int DEPTH          = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter bit CHECK_PARITY   = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ps2_clk,
    input  logic                       ps2_data,
    input  logic                       clr_err,
    output logic [9:0]                 code,
    output logic                       code_valid,
    input  logic                       code_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count,
    output logic                       parity_err,
    output logic                       frame_err,
    output logic                       overflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   ps2_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign ps2_bit = dat_sync[SYNC_STAGES-1];

    state_t         state;
    logic [3:0]     bit_cnt;
    logic [9:0]     shreg;
    logic [TW-1:0]  tmo_cnt;
    logic           expand;
    logic           brk;
    logic           push_vld;
    logic [9:0]     push_dat;

    // shreg collects bits LSB-first: [7:0] byte, [8] parity, [9] stop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            shreg      <= '0;
            tmo_cnt    <= '0;
            expand     <= 1'b0;
            brk        <= 1'b0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            if (clr_err) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (fall && !ps2_bit) begin
                        state   <= RECV;
                        bit_cnt <= 4'd1;
                    end
                end
                RECV: begin
                    if (fall) begin
                        tmo_cnt <= '0;
                        shreg   <= {ps2_bit, shreg[9:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd10) begin
                            state <= CHECK;
                        end
                    end else if (tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
                        frame_err <= 1'b1;
                        expand    <= 1'b0;
                        brk       <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    if (!shreg[9]) begin
                        frame_err <= 1'b1;
                        expand    <= 1'b0;
                        brk       <= 1'b0;
                    end else if (CHECK_PARITY && (^shreg[8:0]) != 1'b1) begin
                        parity_err <= 1'b1;
                        expand     <= 1'b0;
                        brk        <= 1'b0;
                    end else if (shreg[7:0] == 8'hE0) begin
                        expand <= 1'b1;
                    end else if (shreg[7:0] == 8'hF0) begin
                        brk <= 1'b1;
                    end else begin
                        push_vld <= 1'b1;
                        push_dat <= {expand, brk, shreg[7:0]};
                        expand   <= 1'b0;
                        brk      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [9:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          push_ok;

    assign code_valid = (count != '0);
    assign fifo_count = count;
    assign full       = (count == CW'(DEPTH));
    assign pop        = code_valid & code_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push_ok    = push_vld & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            code     <= '0;
            overflow <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow <= 1'b0;
            end
            if (push_vld && full && !pop) begin
                overflow <= 1'b1;
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // keep code equal to the head entry; hold it when the FIFO drains
            if (pop) begin
                if (count > CW'(1)) begin
                    code <= mem[rd_ptr + 1'b1];
                end else if (push_ok) begin
                    code <= push_dat;
                end
            end else if (count == '0 && push_ok) begin
                code <= push_dat;
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;
    localparam int TO    = 300;
    localparam int HALF  = 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic k_clk = 1'b1, k_data = 1'b1, n_clk = 1'b1, n_data = 1'b1;
    logic clr_err = 1'b0, code_ready = 1'b0, n_ready = 1'b0;

    logic [9:0] code, n_code;
    logic       code_valid, n_valid;
    logic [3:0] fifo_count, n_count;
    logic       parity_err, frame_err, overflow;
    logic       n_perr, n_ferr, n_ovf;

    int checks = 0;
    int failures = 0;
    int valid_cycles = 0;
    logic [9:0] exp_q[$];

    ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .CHECK_PARITY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(k_clk), .ps2_data(k_data), .clr_err(clr_err),
        .code(code), .code_valid(code_valid), .code_ready(code_ready), .fifo_count(fifo_count),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    ps2_rx_fifo #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TO), .CHECK_PARITY(1'b0)) dut_np (
        .clk(clk), .rst_n(rst_n), .ps2_clk(n_clk), .ps2_data(n_data), .clr_err(clr_err),
        .code(n_code), .code_valid(n_valid), .code_ready(n_ready), .fifo_count(n_count),
        .parity_err(n_perr), .frame_err(n_ferr), .overflow(n_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every accepted head entry must match the oldest expected code
    always @(negedge clk) begin
        if (rst_n) begin
            if (code_valid) valid_cycles++;
            if (code_valid && code_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL pop_unexpected observed=%0h expected=none", code);
                end else begin
                    chk("pop_code", {22'd0, code}, {22'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // present one bit and drop the PS/2 clock half a bit later
    task automatic ps2_bit(input bit sel, input logic b);
        if (sel) n_data = b; else k_data = b;
        cycles(HALF);
        if (sel) n_clk = 1'b0; else k_clk = 1'b0;
    endtask

    task automatic ps2_rise(input bit sel);
        cycles(HALF);
        if (sel) n_clk = 1'b1; else k_clk = 1'b1;
    endtask

    // ends right after the stop-bit falling edge
    task automatic send_frame(input bit sel, input logic [7:0] b, input logic par_flip, input logic stop);
        logic [10:0] bits;
        bits = {stop, (~^b) ^ par_flip, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_bit(sel, bits[i]);
            if (i < 10) ps2_rise(sel);
        end
    endtask

    task automatic finish_frame(input bit sel);
        ps2_rise(sel);
        if (sel) n_data = 1'b1; else k_data = 1'b1;
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        send_frame(sel, b, 1'b0, 1'b1);
        finish_frame(sel);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
    endtask

    initial begin
        int n;
        // reset state
        cycles(3);
        chk("rst_code", {22'd0, code}, 32'h0);
        chk("rst_valid", {31'd0, code_valid}, 32'd0);
        chk("rst_count", {28'd0, fifo_count}, 32'd0);
        chk("rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        rst_n = 1'b1;
        cycles(3);

        // single make code, latency and one-cycle valid pulse
        code_ready = 1'b1;
        valid_cycles = 0;
        exp_q.push_back(10'h01C);
        send_frame(0, 8'h1C, 1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            n++;
            if (code_valid) break;
        end
        chk("latency", n, SYNC + 3);
        finish_frame(0);
        cycles(10);
        chk("make_valid_pulse", valid_cycles, 1);
        chk("make_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);

        // extended break E0 F0 75
        code_ready = 1'b0;
        send(0, 8'hE0);
        send(0, 8'hF0);
        cycles(10);
        chk("ext_prefix_count", {28'd0, fifo_count}, 32'd0);
        send(0, 8'h75);
        cycles(10);
        chk("ext_count", {28'd0, fifo_count}, 32'd1);
        chk("ext_code", {22'd0, code}, 32'h375);
        exp_q.push_back(10'h375);
        code_ready = 1'b1;
        cycles(5);
        chk("ext_drained", {28'd0, fifo_count}, 32'd0);

        // parity fault, then the same frame on the parity-ignoring instance
        send_frame(0, 8'h1C, 1'b1, 1'b1);
        finish_frame(0);
        cycles(10);
        chk("par_err", {31'd0, parity_err}, 32'd1);
        chk("par_count", {28'd0, fifo_count}, 32'd0);
        pulse_clr();
        chk("par_clr", {31'd0, parity_err}, 32'd0);
        send_frame(1, 8'h1C, 1'b1, 1'b1);
        finish_frame(1);
        cycles(10);
        chk("np_valid", {31'd0, n_valid}, 32'd1);
        chk("np_code", {22'd0, n_code}, 32'h01C);
        chk("np_flags", {30'd0, n_perr, n_ferr}, 32'd0);

        // bad stop bit
        send_frame(0, 8'h1C, 1'b0, 1'b0);
        finish_frame(0);
        cycles(10);
        chk("stop_ferr", {31'd0, frame_err}, 32'd1);
        chk("stop_count", {28'd0, fifo_count}, 32'd0);
        pulse_clr();

        // timeout after start + 4 bits, then a clean frame
        ps2_bit(0, 1'b0);
        ps2_rise(0);
        for (int i = 0; i < 4; i++) begin
            ps2_bit(0, 1'b1);
            ps2_rise(0);
        end
        k_data = 1'b1;
        cycles(TO + 10);
        chk("tmo_ferr", {31'd0, frame_err}, 32'd1);
        chk("tmo_count", {28'd0, fifo_count}, 32'd0);
        pulse_clr();
        chk("tmo_clr", {31'd0, frame_err}, 32'd0);
        exp_q.push_back(10'h01C);
        send(0, 8'h1C);
        cycles(10);
        chk("tmo_recover_empty", {28'd0, fifo_count}, 32'd0);

        // overflow: DEPTH+1 codes with no reads
        code_ready = 1'b0;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            send(0, 8'(i));
            if (i <= DEPTH) exp_q.push_back(10'(i));
        end
        cycles(10);
        chk("ovf_count", {28'd0, fifo_count}, 32'd8);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_head", {22'd0, code}, 32'h001);
        pulse_clr();
        chk("ovf_clr", {31'd0, overflow}, 32'd0);

        // full FIFO: pop in the very cycle the next code is written
        send_frame(0, 8'h0A, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1 code_ready = 1'b1;
        cycles(1);
        code_ready = 1'b0;
        exp_q.push_back(10'h00A);
        chk("fullpp_count", {28'd0, fifo_count}, 32'd8);
        chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
        finish_frame(0);
        code_ready = 1'b1;
        cycles(20);
        chk("drain_count", {28'd0, fifo_count}, 32'd0);

        // reset mid-frame and mid-prefix
        code_ready = 1'b0;
        send(0, 8'h33);
        send_frame(0, 8'h1C, 1'b1, 1'b1);
        finish_frame(0);
        send(0, 8'hE0);
        ps2_bit(0, 1'b0);
        ps2_rise(0);
        ps2_bit(0, 1'b1);
        ps2_rise(0);
        ps2_bit(0, 1'b0);
        cycles(5);
        chk("prerst_count", {28'd0, fifo_count}, 32'd1);
        chk("prerst_perr", {31'd0, parity_err}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, code_valid}, 32'd0);
        chk("midrst_count", {28'd0, fifo_count}, 32'd0);
        chk("midrst_code", {22'd0, code}, 32'h0);
        chk("midrst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        k_clk = 1'b1;
        k_data = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(3);
        code_ready = 1'b1;
        exp_q.push_back(10'h01C);
        send(0, 8'h1C);
        cycles(10);
        chk("postrst_count", {28'd0, fifo_count}, 32'd0);
        chk("postrst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
